if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
- Parametrised instruction-fetch front end for the ARM pipeline. Sits between the instruction RAM and the IF/ID pipeline register.
- Generates the fetch PC, buffers up to DEPTH fetched instructions with their PCs, and presents the queue head to the IF/ID stage.
- Honours hazard-unit stalls (LE), flushes on taken branches, and flags misaligned branch targets.
- Replaces the single-word PC+4 fetch path with a decoupled, multi-entry prefetcher.

Parameters:
- INST_WIDTH, 32, instruction word width in bits.
- PC_WIDTH, 32, fetch address width in bits.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, fetch address loaded on reset.
- PC_STEP, 4, byte increment per fetched instruction.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  synchronous, active-high reset.
- LE  in  1  IF/ID load enable from the hazard unit; 1 = consume the head this cycle.
- branch_taken  in  1  redirect request from the condition handler.
- branch_target  in  PC_WIDTH  redirect address.
- imem_addr  out  PC_WIDTH  fetch address to the instruction RAM; combinational from the fetch PC.
- imem_data  in  INST_WIDTH  instruction read from the RAM, same cycle as the address.
- imem_ready  in  1  1 = imem_data is valid this cycle.
- ifid_inst  out  INST_WIDTH  instruction at the queue head.
- ifid_pc  out  PC_WIDTH  PC of the head instruction.
- ifid_valid  out  1  1 = the queue is non-empty.
- queue_count  out  clog2(DEPTH)+1  number of occupied entries.
- align_fault  out  1  sticky; set when a taken branch target has a nonzero [1:0].

Behaviour:
- Reset (CLR=1 at an edge):
  - fetch PC = RESET_PC; read/write pointers = 0; count = 0.
  - align_fault = 0; ifid_valid = 0; ifid_inst = 0; ifid_pc = 0.
  - imem_addr = RESET_PC while CLR is held.
  - CLR overrides every other input, including mid-branch and mid-stall.
- Priority per edge: CLR > branch_taken > push/pop.
- Pop: occurs when LE=1 and count>0. Read pointer +1 modulo DEPTH. LE=1 with an empty queue is a no-op.
- Push: occurs when imem_ready=1 and (count<DEPTH, or a pop happens the same cycle).
  - Write {fetch PC, imem_data} at the write pointer; write pointer +1 modulo DEPTH.
  - Fetch PC += PC_STEP, wrapping modulo 2^PC_WIDTH.
- Full queue with no pop: no push, fetch PC holds, imem_addr holds.
- Simultaneous push and pop: count unchanged; full stays full; empty cannot pop.
- count update: +1 on push only, -1 on pop only, otherwise unchanged.
- Branch (branch_taken=1):
  - Queue flushed (pointers and count = 0); the pop and push that cycle are discarded.
  - Fetch PC = {branch_target[PC_WIDTH-1:2], 2'b00}.
  - If branch_target[1:0] != 0, set align_fault. It clears only on CLR.
- Latency:
  - First instruction is valid 1 cycle after CLR deasserts (given imem_ready=1).
  - After a branch edge, the target instruction is valid 1 cycle later: 2-cycle redirect bubble, counted from branch assertion to head valid.
- Outputs ifid_* are driven combinationally from the head entry and are stable between edges. When ifid_valid=0, ifid_inst = 0, which encodes a NOP for the decoder.
- Back-to-back branches: the last one wins; each branch flushes again.
- imem_ready=0: no push; the fetch PC holds; pops continue.

Decomposition:
- Shared package pipeline_pkg: INST_WIDTH, PC_WIDTH, PC_STEP, RESET_PC, NOP_INST=0.
- One sub-module: prefetch_fifo.
  - Parameterised DEPTH × (INST_WIDTH+PC_WIDTH) synchronous FIFO.
  - Ports: push, pop, flush, count.
  - Combinational head read.
- The top level holds the fetch PC register, branch/alignment logic, and push/pop gating.

Test Plan:
- Reset then free-run, LE=1, imem_ready=1, RAM holding words at 0,4,8 -> ifid_pc = 0, 4, 8 on consecutive cycles; ifid_valid rises 1 cycle after CLR falls.
- LE=0 for 6 cycles from reset, DEPTH=4 -> queue_count goes 1,2,3,4,4,4; imem_addr freezes at 0x10; LE=1 then delivers PCs 0,4,8,C in order.
- branch_taken with target 0x40 while count=3 -> next cycle count=0 and ifid_valid=0; following cycle ifid_pc=0x40; the old entries never appear.
- branch_target 0x42 -> fetch resumes at 0x40; align_fault=1 and stays 1 through later branches until CLR.
- CLR asserted while full and branch_taken=1 -> next cycle count=0, imem_addr=RESET_PC, align_fault=0.
- Full queue, LE=1, imem_ready=1 -> count stays 4 and PCs stream without gaps; imem_ready toggling 0/1 -> no duplicated or skipped PCs.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : defaults and small helpers shared by the instruction-fetch
// front end.
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int          INST_WIDTH = 32;
    localparam int          PC_WIDTH   = 32;
    localparam int          PC_STEP    = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    // Queue operation for one edge, packed as {pop, push}.
    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_PUSH = 2'b01,
        Q_POP  = 2'b10,
        Q_BOTH = 2'b11
    } q_op_e;

    function automatic logic is_misaligned(input logic [1:0] lo_bits);
        return |lo_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// prefetch_fifo : DEPTH-entry synchronous FIFO with flush and a combinational
// head read. Callers gate push/pop against full/empty.
// Rev 1.0
// ============================================================================
`default_nettype none

module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    input  wire logic [WIDTH-1:0]           i_wr_data,
    output logic      [WIDTH-1:0]           o_head,
    output logic      [$clog2(DEPTH):0]     o_count
);
    import pipeline_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    q_op_e            w_op;

    assign w_op    = q_op_e'({i_pop, i_push});
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            case (w_op)
                Q_PUSH:  r_count <= r_count + CW'(1);
                Q_POP:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && i_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_prefetch_queue.sv
// ============================================================================
// if_prefetch_queue : decoupled instruction prefetcher feeding the IF/ID stage,
// with branch redirect/flush and a sticky misaligned-target flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_prefetch_queue #(
    parameter int                        INST_WIDTH = pipeline_pkg::INST_WIDTH,
    parameter int                        PC_WIDTH   = pipeline_pkg::PC_WIDTH,
    parameter int                        DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0]       RESET_PC   = PC_WIDTH'(pipeline_pkg::RESET_PC),
    parameter int                        PC_STEP    = pipeline_pkg::PC_STEP
) (
    input  wire logic                       CLK,
    input  wire logic                       CLR,
    input  wire logic                       LE,
    input  wire logic                       branch_taken,
    input  wire logic [PC_WIDTH-1:0]        branch_target,
    output logic      [PC_WIDTH-1:0]        imem_addr,
    input  wire logic [INST_WIDTH-1:0]      imem_data,
    input  wire logic                       imem_ready,
    output logic      [INST_WIDTH-1:0]      ifid_inst,
    output logic      [PC_WIDTH-1:0]        ifid_pc,
    output logic                            ifid_valid,
    output logic      [$clog2(DEPTH):0]     queue_count,
    output logic                            align_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_WIDTH + PC_WIDTH;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_align_fault;
    logic [CW-1:0]       w_count;
    logic [EW-1:0]       w_head;
    logic                w_pop;
    logic                w_push;
    logic                w_valid;

    assign w_valid = (w_count != '0);
    assign w_pop   = LE && w_valid;
    // A full queue still accepts a word when the head leaves on the same edge.
    assign w_push  = imem_ready && ((w_count < CW'(DEPTH)) || w_pop);

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (CLK),
        .rst       (CLR),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (branch_taken),
        .i_wr_data ({r_pc, imem_data}),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_pc          <= RESET_PC;
            r_align_fault <= 1'b0;
        end else if (branch_taken) begin
            r_pc <= {branch_target[PC_WIDTH-1:2], 2'b00};
            if (pipeline_pkg::is_misaligned(branch_target[1:0])) begin
                r_align_fault <= 1'b1;
            end
        end else if (w_push) begin
            r_pc <= r_pc + PC_WIDTH'(PC_STEP);
        end
    end

    assign imem_addr   = r_pc;
    assign queue_count = w_count;
    assign ifid_valid  = w_valid;
    assign align_fault = r_align_fault;
    // An empty queue presents a NOP so the decoder sees a bubble.
    assign ifid_inst   = w_valid ? w_head[INST_WIDTH-1:0]
                                 : INST_WIDTH'(pipeline_pkg::NOP_INST);
    assign ifid_pc     = w_valid ? w_head[EW-1:INST_WIDTH] : '0;

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
// ============================================================================
// tb_if_prefetch_queue : scoreboard bench for the instruction prefetch queue.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        LE = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready = 1'b1;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic [2:0]  queue_count;
    logic        align_fault;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_af = 1'b0;

    if_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .CLR           (CLR),
        .LE            (LE),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .imem_ready    (imem_ready),
        .ifid_inst     (ifid_inst),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .queue_count   (queue_count),
        .align_fault   (align_fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = ram_word(imem_addr);

    // One clock: predict pop/push from the model, score the consumed head,
    // then advance the model and compare occupancy state after the edge.
    task automatic step();
        logic        pop;
        logic        push;
        logic [31:0] exp_pc;
        #1;
        pop  = LE && (sb.size() > 0) && !CLR && !branch_taken;
        push = imem_ready && ((sb.size() < DEPTH) || pop) && !CLR && !branch_taken;
        if (pop) begin
            exp_pc = sb.pop_front();
            checks++;
            if (ifid_pc !== exp_pc || ifid_inst !== ram_word(exp_pc)) begin
                failures++;
                $display("FAIL pop_order: got pc=%h inst=%h, expected pc=%h inst=%h",
                         ifid_pc, ifid_inst, exp_pc, ram_word(exp_pc));
            end
        end
        if (push) begin
            checks++;
            if (imem_addr !== m_pc) begin
                failures++;
                $display("FAIL fetch_addr: got %h, expected %h", imem_addr, m_pc);
            end
            sb.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        @(posedge CLK);
        if (CLR) begin
            sb.delete();
            m_pc = 32'h0;
            m_af = 1'b0;
        end else if (branch_taken) begin
            sb.delete();
            m_pc = {branch_target[31:2], 2'b00};
            if (branch_target[1:0] != 2'b00) m_af = 1'b1;
        end
        #1;
        checks++;
        if (queue_count !== 3'(sb.size()) || ifid_valid !== (sb.size() != 0) ||
            align_fault !== m_af) begin
            failures++;
            $display("FAIL state: got count=%0d valid=%0b af=%0b, expected count=%0d valid=%0b af=%0b",
                     queue_count, ifid_valid, align_fault, sb.size(), (sb.size() != 0), m_af);
        end
    endtask

    task automatic do_reset();
        CLR = 1'b1; branch_taken = 1'b0; LE = 1'b0; imem_ready = 1'b1;
        step();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0043; LE = 1'b1;
        step();
        step();
        checks++;
        if (queue_count !== 3'd0 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0 ||
            ifid_pc !== 32'h0 || imem_addr !== 32'h0 || align_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset: got count=%0d valid=%0b inst=%h pc=%h addr=%h af=%0b, expected all zero",
                     queue_count, ifid_valid, ifid_inst, ifid_pc, imem_addr, align_fault);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'h0; exp_pcs[1] = 32'h4; exp_pcs[2] = 32'h8;
        do_reset();
        LE = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== exp_pcs[i]) begin
                failures++;
                $display("FAIL stream_%0d: got valid=%0b pc=%h, expected valid=1 pc=%h",
                         i, ifid_valid, ifid_pc, exp_pcs[i]);
            end
        end
    endtask

    task automatic test_fill();
        logic [2:0] exp_cnt [6];
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd3;
        exp_cnt[3] = 3'd4; exp_cnt[4] = 3'd4; exp_cnt[5] = 3'd4;
        do_reset();
        LE = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (queue_count !== exp_cnt[i]) begin
                failures++;
                $display("FAIL fill_count_%0d: got %0d, expected %0d", i, queue_count, exp_cnt[i]);
            end
        end
        checks++;
        if (imem_addr !== 32'h10) begin
            failures++;
            $display("FAIL fill_addr_freeze: got %h, expected 00000010", imem_addr);
        end
        LE = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_branch();
        do_reset();
        LE = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        branch_taken = 1'b1; branch_target = 32'h40; LE = 1'b1;
        step();
        branch_taken = 1'b0;
        checks++;
        if (queue_count !== 3'd0 || ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin
            failures++;
            $display("FAIL branch_flush: got count=%0d valid=%0b inst=%h, expected 0 0 00000000",
                     queue_count, ifid_valid, ifid_inst);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40) begin
            failures++;
            $display("FAIL branch_target_head: got valid=%0b pc=%h, expected 1 00000040",
                     ifid_valid, ifid_pc);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_misaligned();
        LE = 1'b1; imem_ready = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h42;
        step();
        branch_taken = 1'b0;
        checks++;
        if (imem_addr !== 32'h40 || align_fault !== 1'b1) begin
            failures++;
            $display("FAIL misaligned: got addr=%h af=%0b, expected 00000040 1", imem_addr, align_fault);
        end
        for (int i = 0; i < 3; i++) step();
        branch_taken = 1'b1; branch_target = 32'h80;
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (align_fault !== 1'b1) begin
            failures++;
            $display("FAIL align_sticky: got %0b, expected 1", align_fault);
        end
    endtask

    task automatic test_clr_priority();
        LE = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        CLR = 1'b1; branch_taken = 1'b1; branch_target = 32'h123;
        step();
        CLR = 1'b0; branch_taken = 1'b0;
        checks++;
        if (queue_count !== 3'd0 || imem_addr !== 32'h0 || align_fault !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: got count=%0d addr=%h af=%0b, expected 0 00000000 0",
                     queue_count, imem_addr, align_fault);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        LE = 1'b1; imem_ready = 1'b1;
        step(); step();
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_target = 32'h204;
        step();
        branch_taken = 1'b0;
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h204) begin
            failures++;
            $display("FAIL back_to_back: got valid=%0b pc=%h, expected 1 00000204", ifid_valid, ifid_pc);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_full_stream();
        do_reset();
        LE = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        LE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (queue_count !== 3'd4) begin
                failures++;
                $display("FAIL full_stream_%0d: got count=%0d, expected 4", i, queue_count);
            end
        end
    endtask

    task automatic test_wrap();
        LE = 1'b1; imem_ready = 1'b1;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (ifid_pc !== 32'h4 || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL pc_wrap: got head=%h addr=%h, expected 00000004 00000008", ifid_pc, imem_addr);
        end
    endtask

    task automatic test_ready_toggle();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            LE = ($urandom_range(0, 3) != 0);
            step();
        end
        imem_ready = 1'b0; LE = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (queue_count !== 3'd0 || ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL toggle_drain: got count=%0d valid=%0b, expected 0 0", queue_count, ifid_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_branch();
        test_misaligned();
        test_clr_priority();
        test_back_to_back();
        test_full_stream();
        test_wrap();
        test_ready_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
